// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; remembers the last granted port.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output port_t      gnt_id,
  output logic       any
);

  port_t last;

  always_comb begin
    any    = |req;
    gnt_id = PORT_IF;
    if (req[PORT_D] && req[PORT_IF])
      gnt_id = (last == PORT_IF) ? PORT_D : PORT_IF;
    else if (req[PORT_D])
      gnt_id = PORT_D;
  end

  // Pointer starts at fetch so the first tie goes to the data port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= PORT_IF;
    else if (advance)
      last <= gnt_id;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one byte-addressed memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout
);

  localparam logic [15:0] ADDR_MAX = 16'(MEM_BYTES - 2);

  state_t      state;
  port_t       win;
  port_t       pick;
  logic        pick_any;
  logic        arb_adv;
  logic [15:0] sel_addr;
  logic        sel_oor;

  assign arb_adv  = (state == ST_IDLE) && pick_any;
  assign sel_addr = (pick == PORT_D) ? d_addr : if_addr;
  assign sel_oor  = sel_addr > ADDR_MAX;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({d_req, if_req}),
    .advance (arb_adv),
    .gnt_id  (pick),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      win      <= PORT_IF;
      if_gnt   <= 1'b0;
      if_valid <= 1'b0;
      if_rdata <= '0;
      d_gnt    <= 1'b0;
      d_valid  <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
      mem_rw   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            win <= pick;
            if (pick == PORT_D) d_gnt  <= 1'b1;
            else                if_gnt <= 1'b1;
            // Out-of-range: complete in the grant cycle without driving memory.
            if (sel_oor) begin
              state <= ST_RESP;
              if (pick == PORT_D) begin
                d_valid <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                if_valid <= 1'b1;
                if_rdata <= '0;
              end
            end else begin
              state    <= ST_ACCESS;
              mem_addr <= sel_addr;
              if (pick == PORT_D && d_we) begin
                mem_rw  <= 1'b1;
                mem_din <= d_wdata;
              end
            end
          end
        end
        ST_ACCESS: begin
          state  <= ST_RESP;
          mem_rw <= 1'b0;
          if (win == PORT_D) begin
            d_valid <= 1'b1;
            if (!mem_rw) d_rdata <= mem_dout;
          end else begin
            if_valid <= 1'b1;
            if_rdata <= mem_dout;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 64-byte memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic        d_err;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  logic [7:0]  mem [0:63];
  int          total;
  int          bad;
  int          rw_cycles;
  int          rw_snap;

  mem_arbiter #(.MEM_BYTES(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_valid  (d_valid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preload while in reset, otherwise behave as a write-on-edge memory.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[16'h10] <= 8'hAB;
      mem[16'h11] <= 8'hCD;
      mem[16'h12] <= 8'hEF;
      mem[16'h3E] <= 8'h77;
      mem[16'h3F] <= 8'h88;
    end else if (mem_rw) begin
      mem[mem_addr[5:0]]        <= mem_din[15:8];
      mem[mem_addr[5:0] + 6'd1] <= mem_din[7:0];
    end
  end

  always_comb begin
    mem_dout = '0;
    if (mem_addr < 16'd63)
      mem_dout = {mem[mem_addr[5:0]], mem[mem_addr[5:0] + 6'd1]};
  end

  initial rw_cycles = 0;
  always @(negedge clk) if (mem_rw === 1'b1) rw_cycles = rw_cycles + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_d(input logic [15:0] a);
    d_req = 1'b1; d_we = 1'b0; d_addr = a;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #12;
    chk("rst_flags", 32'({if_gnt, if_valid, d_gnt, d_valid, d_err, mem_rw}), 32'h0);
    chk("rst_if_rdata", 32'(if_rdata), 32'h0);
    chk("rst_d_rdata", 32'(d_rdata), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_din", 32'(mem_din), 32'h0);
    rst_n = 1'b1;

    // Both ports requesting from reset: data first, then alternate.
    if_req = 1'b1; if_addr = 16'h0010;
    read_d(16'h0012);
    for (int g = 0; g < 4; g++) begin
      tick;
      chk("rr_gnt", 32'({d_gnt, if_gnt}), (g % 2 == 0) ? 32'h2 : 32'h1);
      tick;
      tick;
    end
    if_req = 1'b0; d_req = 1'b0;
    tick; tick; tick;

    // Fetch word at 0x10.
    if_req = 1'b1; if_addr = 16'h0010;
    tick;
    chk("if_gnt", 32'({if_gnt, d_gnt, if_valid}), 32'h4);
    chk("if_mem_addr", 32'(mem_addr), 32'h0010);
    if_req = 1'b0;
    tick;
    chk("if_valid", 32'(if_valid), 32'h1);
    chk("if_rdata", 32'(if_rdata), 32'hABCD);
    tick;
    chk("if_valid_pulse", 32'(if_valid), 32'h0);

    // Write 0x1234 to 0x20.
    rw_snap = rw_cycles;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    tick;
    chk("wr_gnt", 32'(d_gnt), 32'h1);
    chk("wr_mem_rw", 32'(mem_rw), 32'h1);
    chk("wr_mem_din", 32'(mem_din), 32'h1234);
    d_req = 1'b0; d_we = 1'b0;
    tick;
    chk("wr_valid", 32'({d_valid, d_err, mem_rw}), 32'h4);
    chk("wr_bytes", 32'({mem[16'h20], mem[16'h21]}), 32'h1234);
    tick;
    chk("wr_rw_once", 32'(rw_cycles - rw_snap), 32'h1);

    // Read back 0x20; fetch rdata must hold.
    read_d(16'h0020);
    tick;
    chk("rd_gnt", 32'({d_gnt, mem_rw}), 32'h2);
    d_req = 1'b0;
    tick;
    chk("rd_rdata", 32'({d_valid, d_err, d_rdata}), 32'h2_1234);
    chk("rd_if_hold", 32'(if_rdata), 32'hABCD);
    tick;

    // Odd address 0x11.
    read_d(16'h0011);
    tick;
    d_req = 1'b0;
    tick;
    chk("odd_rdata", 32'({d_valid, d_err, d_rdata}), 32'h2_CDEF);
    tick;

    // Highest in-range address 0x3E.
    read_d(16'h003E);
    tick;
    chk("max_no_early_valid", 32'({d_gnt, d_valid}), 32'h2);
    d_req = 1'b0;
    tick;
    chk("max_rdata", 32'({d_valid, d_err, d_rdata}), 32'h2_7788);
    tick;

    // Out of range 0x3F: completes in the grant cycle with an error.
    rw_snap = rw_cycles;
    read_d(16'h003F);
    tick;
    chk("oor_d", 32'({d_gnt, d_valid, d_err, d_rdata}), 32'h7_0000);
    d_req = 1'b0;
    tick;
    chk("oor_d_pulse", 32'({d_valid, d_err}), 32'h0);
    tick;
    chk("oor_no_rw", 32'(rw_cycles - rw_snap), 32'h0);

    // Fetch out of range: zero data, no error flag.
    if_req = 1'b1; if_addr = 16'h0040;
    tick;
    chk("oor_if", 32'({if_gnt, if_valid, d_err, if_rdata}), 32'h6_0000);
    if_req = 1'b0;
    tick; tick;

    // Reset in the middle of a write access.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
    tick;
    chk("abort_rw_before", 32'(mem_rw), 32'h1);
    d_req = 1'b0; d_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rw_async", 32'({mem_rw, d_gnt, d_valid}), 32'h0);
    tick;
    #2 rst_n = 1'b1;
    tick;
    chk("abort_no_valid", 32'({d_valid, d_err, mem_rw}), 32'h0);
    tick;
    chk("abort_no_valid2", 32'(d_valid), 32'h0);
    if_req = 1'b1; if_addr = 16'h0010;
    tick;
    chk("abort_idle_gnt", 32'(if_gnt), 32'h1);
    if_req = 1'b0;
    tick;
    chk("abort_after_rdata", 32'({if_valid, if_rdata}), 32'h1_ABCD);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
